// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller with multi-cycle EX wait and stall-cycle counter
module stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_start,
  input  logic [5:0]  ex_cycles,
  input  logic        ex_done,
  input  logic        flush_req,
  input  logic        perf_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        busy,
  output logic [5:0]  ex_cnt,
  output logic [15:0] stall_cycles
);
  typedef enum logic [1:0] {RUN, EX_WAIT, FLUSH} state_t;
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] ID   = 6'b000111;
  localparam logic [5:0] EX   = 6'b001111;
  state_t      r_state, w_next;
  logic [5:0]  r_cnt, w_cnt_nxt, w_stall;
  logic [15:0] r_sc;
  logic        w_last;
  assign w_last = (r_cnt == 6'd1) || ex_done;
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_stall   = NONE;
    if (flush_req) begin
      w_next    = FLUSH;
      w_cnt_nxt = '0;
    end else if (r_state == EX_WAIT) begin
      w_stall   = EX;
      w_next    = w_last ? RUN : EX_WAIT;
      w_cnt_nxt = w_last ? 6'd0 : r_cnt - 6'd1;
    end else if (r_state == FLUSH) begin
      w_next = RUN;
    end else if (ex_start && ex_cycles != 6'd0) begin
      w_stall = EX;
      if (ex_cycles != 6'd1) begin
        w_next    = EX_WAIT;
        w_cnt_nxt = ex_cycles - 6'd1;
      end
    end else begin
      w_stall = stallreq_id ? ID : NONE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sc <= '0;
    else if (perf_clr) r_sc <= '0;
    else if (stall[0] && r_sc != 16'hFFFF) r_sc <= r_sc + 16'd1;
  end
  assign stall        = rst ? w_stall : NONE;
  assign flush        = (r_state == FLUSH);
  assign busy         = (r_state != RUN);
  assign ex_cnt       = r_cnt;
  assign stall_cycles = r_sc;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: table-driven directed vectors plus reset and counter-saturation sequences
module tb_stall_ctrl;
  localparam logic [5:0] N = 6'b000000;
  localparam logic [5:0] I = 6'b000111;
  localparam logic [5:0] E = 6'b001111;
  typedef struct {
    logic        id, st;
    logic [5:0]  cyc;
    logic        dn, fr, pc;
    logic [5:0]  e_stall;
    logic        e_flush, e_busy;
    logic [5:0]  e_cnt;
    logic [15:0] e_sc;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst, stallreq_id, ex_start, ex_done, flush_req, perf_clr;
  logic [5:0]  ex_cycles, stall, ex_cnt;
  logic        flush, busy;
  logic [15:0] stall_cycles;
  int          checks = 0;
  int          errors = 0;
  vec_t        v[31];
  stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
    .ex_cycles(ex_cycles), .ex_done(ex_done), .flush_req(flush_req),
    .perf_clr(perf_clr), .stall(stall), .flush(flush), .busy(busy),
    .ex_cnt(ex_cnt), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic id, st, input logic [5:0] cyc, input logic dn, fr, pc,
                              input logic [5:0] es, input logic ef, eb, input logic [5:0] ec,
                              input logic [15:0] esc);
    vec_t r;
    r.id = id; r.st = st; r.cyc = cyc; r.dn = dn; r.fr = fr; r.pc = pc;
    r.e_stall = es; r.e_flush = ef; r.e_busy = eb; r.e_cnt = ec; r.e_sc = esc;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic drive(input logic id, st, input logic [5:0] cyc, input logic dn, fr, pc);
    stallreq_id = id; ex_start = st; ex_cycles = cyc; ex_done = dn; flush_req = fr; perf_clr = pc;
  endtask
  initial begin
    v[0]  = mk(0,0,0, 0,0,0, N,0,0,0,0);
    v[1]  = mk(1,0,0, 0,0,0, I,0,0,0,0);
    v[2]  = mk(1,0,0, 0,0,0, I,0,0,0,1);
    v[3]  = mk(0,0,0, 0,0,0, N,0,0,0,2);
    v[4]  = mk(0,1,4, 0,0,0, E,0,0,0,2);
    v[5]  = mk(1,1,0, 0,0,0, E,0,1,3,3);
    v[6]  = mk(0,0,0, 0,0,0, E,0,1,2,4);
    v[7]  = mk(0,0,0, 0,0,0, E,0,1,1,5);
    v[8]  = mk(0,0,0, 0,0,0, N,0,0,0,6);
    v[9]  = mk(0,1,1, 0,0,0, E,0,0,0,6);
    v[10] = mk(0,0,0, 0,0,0, N,0,0,0,7);
    v[11] = mk(0,1,0, 0,0,0, N,0,0,0,7);
    v[12] = mk(1,1,0, 0,0,0, I,0,0,0,7);
    v[13] = mk(0,1,10,0,0,0, E,0,0,0,8);
    v[14] = mk(0,0,0, 0,0,0, E,0,1,9,9);
    v[15] = mk(0,0,0, 1,0,0, E,0,1,8,10);
    v[16] = mk(0,0,0, 0,0,0, N,0,0,0,11);
    v[17] = mk(0,1,6, 0,0,0, E,0,0,0,11);
    v[18] = mk(0,0,0, 0,0,0, E,0,1,5,12);
    v[19] = mk(0,0,0, 0,1,0, N,0,1,4,13);
    v[20] = mk(1,1,4, 0,0,0, N,1,1,0,13);
    v[21] = mk(0,0,0, 0,0,0, N,0,0,0,13);
    v[22] = mk(0,1,3, 0,1,0, N,0,0,0,13);
    v[23] = mk(0,0,0, 0,1,0, N,1,1,0,13);
    v[24] = mk(0,0,0, 0,0,0, N,1,1,0,13);
    v[25] = mk(0,0,0, 0,0,0, N,0,0,0,13);
    v[26] = mk(1,0,0, 0,0,1, I,0,0,0,13);
    v[27] = mk(0,0,0, 0,0,0, N,0,0,0,0);
    v[28] = mk(0,1,2, 0,0,0, E,0,0,0,0);
    v[29] = mk(0,0,0, 0,0,0, E,0,1,1,1);
    v[30] = mk(0,0,0, 0,0,0, N,0,0,0,2);
    rst = 1'b0;
    drive(1,1,4,0,1,0);
    #3;
    chk("reset stall", {10'd0, stall}, 16'd0);
    chk("reset flush", {15'd0, flush}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset ex_cnt", {10'd0, ex_cnt}, 16'd0);
    chk("reset stall_cycles", stall_cycles, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(0,0,0,0,0,0);
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      drive(v[k].id, v[k].st, v[k].cyc, v[k].dn, v[k].fr, v[k].pc);
      #1;
      chk($sformatf("v%0d stall", k), {10'd0, stall}, {10'd0, v[k].e_stall});
      chk($sformatf("v%0d flush", k), {15'd0, flush}, {15'd0, v[k].e_flush});
      chk($sformatf("v%0d busy", k), {15'd0, busy}, {15'd0, v[k].e_busy});
      chk($sformatf("v%0d ex_cnt", k), {10'd0, ex_cnt}, {10'd0, v[k].e_cnt});
      chk($sformatf("v%0d stall_cycles", k), stall_cycles, v[k].e_sc);
    end
    @(negedge clk);
    drive(0,1,7,0,0,0);
    @(negedge clk);
    drive(0,0,0,0,0,0);
    @(negedge clk);
    #1;
    chk("midwait ex_cnt", {10'd0, ex_cnt}, 16'd5);
    chk("midwait stall", {10'd0, stall}, {10'd0, E});
    drive(1,1,3,0,0,0);
    #2 rst = 1'b0;
    #1;
    chk("async rst stall", {10'd0, stall}, 16'd0);
    chk("async rst ex_cnt", {10'd0, ex_cnt}, 16'd0);
    chk("async rst busy", {15'd0, busy}, 16'd0);
    chk("async rst stall_cycles", stall_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0,0,0,0,0,0);
    #1;
    chk("post rst stall", {10'd0, stall}, 16'd0);
    chk("post rst busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    #1;
    chk("post rst stall2", {10'd0, stall}, 16'd0);
    @(negedge clk);
    drive(1,0,0,0,0,0);
    repeat (65534) @(negedge clk);
    #1;
    chk("sc preload", stall_cycles, 16'hFFFE);
    @(negedge clk);
    #1;
    chk("sc reach max", stall_cycles, 16'hFFFF);
    @(negedge clk);
    #1;
    chk("sc saturate", stall_cycles, 16'hFFFF);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
    chk("sc clear", stall_cycles, 16'd0);
    @(negedge clk);
    #1;
    chk("sc resume", stall_cycles, 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
